seg7_scan: RTL and testbench
============================

# seg7_scan

Four-digit multiplexed seven-segment display driver for the board I/O path. It sits directly downstream of the switch/LED logic. It takes a 16-bit value, such as the `led` or `sw` bus, and shows it as four hex digits on a common-anode display. Digits are scanned one at a time, with a programmable dwell time and an anti-ghost blanking window. The displayed value is latched once per frame so the digits never tear.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ 4.
- `BLANK`, default 2: cycles at the start of each slot with all anodes off. Range 1 ≤ `BLANK` < `CLK_DIV`.
- `clk`, input, 1: system clock. The block has one clock; everything is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data`, input, 16: value to display. Digit 0 = `data[3:0]` (rightmost); digit 3 = `data[15:12]`.
- `dp`, input, 4: decimal-point request per digit, active-high, bit i = digit i.
- `en`, input, 1: display enable. 0 blanks the display; the counters keep running.
- `an`, output, 4: anode selects, active-low, bit i = digit i.
- `seg`, output, 7: cathodes, active-low, `seg[6:0]` = {g,f,e,d,c,b,a}.
- `dp_n`, output, 1: decimal-point cathode, active-low.

## Operation
- State held by the block:
  - slot counter `cnt`, counting 0..`CLK_DIV`-1;
  - digit index `idx`, 2 bits;
  - frame registers `fdata[15:0]` and `fdp[3:0]`;
  - registered outputs.
- Slot counter:
  - `cnt` increments every cycle.
  - At `CLK_DIV`-1 it wraps to 0 and `idx` increments.
  - `idx` wraps from 3 to 0.
- Frame latch:
  - In every cycle with `cnt`==0 and `idx`==0, `fdata`<=`data` and `fdp`<=`dp`.
  - This includes the first cycle after `rst` deasserts.
  - `data` and `dp` are ignored at all other times; changes mid-frame appear only at the next frame.
- Output computation, registered one cycle after the state it reflects:
  - Blank window: if `en`==0 or `cnt` < `BLANK`, then `an`=4'b1111, `seg`=7'b1111111, `dp_n`=1.
  - Otherwise:
    - `an` = all ones except bit `idx` = 0;
    - `seg` = hex decode of `fdata[4*idx+3:4*idx]`;
    - `dp_n` = ~`fdp[idx]`.
- Hex decode, `seg` values for nibbles 0..F:
  - 0–3: 1000000, 1111001, 0100100, 0110000
  - 4–7: 0011001, 0010010, 0000010, 1111000
  - 8–B: 0000000, 0010000, 0001000, 0000011
  - C–F: 1000110, 0100001, 0000110, 0001110
- At most one anode is low in any cycle. Two anodes are never low simultaneously, even across a digit change.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, `fdata`=0, `fdp`=0;
  - `an`=4'b1111, `seg`=7'b1111111, `dp_n`=1.
- Output latency: 1 cycle from the (`cnt`, `idx`, `fdata`) state.
  - Digit i is driven during output cycles `BLANK`+1 .. `CLK_DIV` of its slot, counted from the cycle where `cnt`==0.
  - That is `CLK_DIV`-`BLANK` cycles per digit.
- Frame period: 4×`CLK_DIV` cycles.
- Data-to-display latency:
  - minimum 1 + `BLANK` cycles;
  - maximum 4×`CLK_DIV` + `BLANK` + 1 cycles.
- Latch safety: `fdata` is updated in a slot-0 cycle that falls inside the blank window, because `BLANK` ≥ 1. A newly latched value is never shown half-updated.
- `rst` mid-scan:
  - the next edge forces all outputs to their reset values;
  - scanning restarts at digit 0, `cnt`=0;
  - frame contents are replaced by the first post-reset latch.
- `en` toggling:
  - takes effect on the output one cycle later;
  - does not disturb `cnt`, `idx` or the frame latch.
- Scan order: `idx` wraps 3→0 with no extra idle cycles.

## Test plan
All scenarios use `CLK_DIV`=8, `BLANK`=2.
- Reset: hold `rst` for 3 cycles with `data`=16'h1234. Then:
  - `an`=1111, `seg`=1111111, `dp_n`=1 while `rst` is high and for 2 cycles after;
  - `an`=1110, `seg`=0011001 ("4") during the following 6 cycles.
- Full scan: `data`=16'hA5F0, `dp`=4'b0100. Over one 32-cycle frame:
  - the `an` sequence is 1110, 1101, 1011, 0111;
  - `seg` is 1000000, 0001110, 0010010, 0001000 respectively;
  - `dp_n`=0 only while `an`=1011;
  - each digit lasts 6 cycles, preceded by 2 all-off cycles.
- Tear-free update: change `data` from 16'h1111 to 16'h2222 while digit 1 is shown.
  - Digits 2 and 3 still show "1".
  - "2" appears from the next frame's digit 0.
- Enable: drop `en` for 10 cycles mid-frame.
  - `an`=1111 starting one cycle after `en` falls.
  - On re-enable, the digit shown matches free-running `idx`; scan phase is unchanged.
- Reset mid-scan: assert `rst` during digit 2's active window.
  - Outputs blank on the next edge.
  - After release, scanning restarts at digit 0 with a freshly latched `data`.
- Exclusivity: across 4 full frames with random `data`/`dp`/`en`, check every cycle that `an` has at most one zero bit.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan
// ---------
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Shows a 16-bit value as four hex digits, one digit lit at a time. Each
// digit slot is CLK_DIV cycles long. The first BLANK cycles of every slot
// keep all anodes off so the previous digit cannot ghost into the next one.
// The displayed value is latched once per frame, at the start of digit 0's
// slot, so a frame never mixes old and new data.
//
// Parameters:
//   CLK_DIV : clock cycles per digit slot (>= 4)
//   BLANK   : all-off cycles at the start of each slot (1 <= BLANK < CLK_DIV)
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   data  : value to display, digit i = data[4*i+3:4*i], digit 0 rightmost
//   dp    : decimal-point request per digit, active-high
//   en    : display enable; 0 blanks the outputs, the scan keeps running
//   an    : anode selects, active-low, bit i = digit i
//   seg   : cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n  : decimal-point cathode, active-low
module seg7_scan #(
  parameter int CLK_DIV = 100000,
  parameter int BLANK   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   fdata;
  logic [3:0]    fdp;

  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_n_next;
  logic [3:0]    nibble;

  // Active-low hex font, indexed by nibble value.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next output values are derived from the present scan state. They are
  // registered below, so the pins trail the state by exactly one cycle.
  // Because the anodes come from a single 2-bit index, at most one anode can
  // ever be low, and every digit change passes through the blank window.
  always_comb begin
    an_next   = 4'b1111;
    seg_next  = 7'b1111111;
    dp_n_next = 1'b1;
    nibble    = fdata[4*idx +: 4];
    if (en && (cnt >= CNT_BLANK)) begin
      an_next   = ~(4'b0001 << idx);
      seg_next  = hex_decode(nibble);
      dp_n_next = ~fdp[idx];
    end
  end

  // Scan counters, frame latch and output registers. The frame is captured
  // when cnt==0 and idx==0. That cycle is always inside digit 0's blank
  // window, so new data never reaches a lit digit partway through a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      fdata <= 16'h0000;
      fdp   <= 4'h0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
      dp_n  <= 1'b1;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if ((cnt == '0) && (idx == 2'd0)) begin
        fdata <= data;
        fdp   <= dp;
      end
      an   <= an_next;
      seg  <= seg_next;
      dp_n <= dp_n_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan
// ------------
// Scoreboard bench for seg7_scan with CLK_DIV=8, BLANK=2. A reference model
// tracks time since reset and computes the expected pins from the slot
// position and frame contents. It pushes one expected word per clock into a
// queue. A monitor on the falling edge pops each word and compares it with
// the pins, and also checks that at most one anode is low.
module tb_seg7_scan;

  localparam int CD = 8;
  localparam int BL = 2;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int vectors;
  int miscompares;
  bit running;

  logic [11:0] expQ[$];

  logic [6:0] hexTab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan #(.CLK_DIV(CD), .BLANK(BL)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .dp   (dp),
    .en   (en),
    .an   (an),
    .seg  (seg),
    .dp_n (dp_n)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and record a failure if it differs.
  task automatic checkOutput(input string name, input logic [11:0] act,
                             input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got an=%b seg=%b dp_n=%b, expected an=%b seg=%b dp_n=%b",
               name, $time, act[11:8], act[7:1], act[0],
               exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Drive the inputs just after a falling edge, then hold them for n cycles.
  task automatic applyStimulus(input logic r, input logic [15:0] d,
                               input logic [3:0] p, input logic e, input int n);
    @(negedge clk);
    rst  = r;
    data = d;
    dp   = p;
    en   = e;
    repeat (n - 1) @(negedge clk);
  endtask

  // Reference model. t counts cycles since reset was released. The digit
  // slot is t/CD mod 4 and the position in the slot is t mod CD. The frame
  // registers reload whenever t is a multiple of the 4*CD frame period.
  // Each expected word is the pin value one clock after the sampled state.
  initial begin : model
    int t;
    int pos;
    int slot;
    logic [15:0] fd;
    logic [3:0]  fp;
    logic [11:0] e;
    t  = 0;
    fd = 16'h0000;
    fp = 4'h0;
    forever begin
      @(posedge clk);
      running = 1'b1;
      if (rst) begin
        e  = {4'b1111, 7'b1111111, 1'b1};
        t  = 0;
        fd = 16'h0000;
        fp = 4'h0;
      end else begin
        pos  = t % CD;
        slot = (t / CD) % 4;
        if (!en || pos < BL) begin
          e = {4'b1111, 7'b1111111, 1'b1};
        end else begin
          e[11:8] = 4'b1111;
          e[8 + slot] = 1'b0;
          e[7:1] = hexTab[(fd >> (4 * slot)) & 16'hF];
          e[0] = ~fp[slot];
        end
        if (t % (4 * CD) == 0) begin
          fd = data;
          fp = dp;
        end
        t = (t + 1) % (4 * CD);
      end
      expQ.push_back(e);
    end
  end

  // Monitor: pop one expected word per cycle and compare it with the pins.
  always @(negedge clk) begin
    if (running) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL scoreboard at %0t: got empty queue, expected one entry", $time);
      end else begin
        checkOutput("pins", {an, seg, dp_n}, expQ.pop_front());
      end
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("[TB] FAIL exclusive at %0t: got an=%b, expected at most one low bit",
                 $time, an);
      end
    end
  end

  initial begin
    running = 1'b0;
    vectors = 0;
    miscompares = 0;
    rst  = 1'b1;
    data = 16'h1234;
    dp   = 4'h0;
    en   = 1'b1;

    // Reset held for 3 cycles, then digit 0 shows "4" after two blank cycles.
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b1, 3);
    applyStimulus(1'b0, 16'h1234, 4'h0, 1'b1, 8);

    // Full scan of A5F0 with the decimal point on digit 2. A fresh reset
    // aligns the frame start.
    applyStimulus(1'b1, 16'hA5F0, 4'b0100, 1'b1, 1);
    applyStimulus(1'b0, 16'hA5F0, 4'b0100, 1'b1, 40);

    // Tear-free update: realign, then change the data during digit 1.
    applyStimulus(1'b1, 16'h1111, 4'h0, 1'b1, 1);
    applyStimulus(1'b0, 16'h1111, 4'h0, 1'b1, 12);
    applyStimulus(1'b0, 16'h2222, 4'h0, 1'b1, 56);

    // Drop enable for 10 cycles mid-frame.
    applyStimulus(1'b0, 16'h2222, 4'h3, 1'b0, 10);
    applyStimulus(1'b0, 16'h2222, 4'h3, 1'b1, 30);

    // Reset during digit 2's active window, with new data.
    applyStimulus(1'b1, 16'hBEEF, 4'h9, 1'b1, 1);
    applyStimulus(1'b0, 16'hBEEF, 4'h9, 1'b1, 20);
    applyStimulus(1'b1, 16'h7C3D, 4'h6, 1'b1, 2);
    applyStimulus(1'b0, 16'h7C3D, 4'h6, 1'b1, 36);

    // Random data, decimal points and enable over many frames.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 16'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) != 0), $urandom_range(1, 6));
    end

    // Hold steady for a few frames so every nibble in the last value shows.
    applyStimulus(1'b0, 16'h89BD, 4'hF, 1'b1, 100);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
